// File: rtl/chacha20_word_serializer.sv
// chacha20_word_serializer
//
// Purpose:
//   Takes a 512-bit ChaCha20 keystream block and hands it out one 32-bit
//   word at a time over a valid/ready handshake. Word k of a block is
//   block_in[32k+31:32k], and word 0 appears the cycle after the block is
//   accepted. When the last word is consumed, a new block can be loaded in
//   the same cycle, so consecutive blocks produce words with no gap.
//
// Parameters:
//   WORDS_PER_BLOCK : number of 32-bit words emitted per block (1..16).
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   clear        in   synchronous clear, active-high; returns to EMPTY
//   block_in     in   [511:0] keystream block
//   block_valid  in   block_in is valid this cycle
//   block_ready  out  block_in is accepted this cycle if block_valid is high
//   word_out     out  [31:0] current keystream word
//   word_valid   out  word_out is valid
//   word_ready   in   downstream consumes word_out this cycle
//   block_count  out  [15:0] wrapping count of accepted blocks; this port
//                     exists only when CHACHA20_SERIALIZER_STATS_EN is
//                     defined
//
// Optional feature macro: CHACHA20_SERIALIZER_STATS_EN

module chacha20_word_serializer #(
  parameter int WORDS_PER_BLOCK = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [511:0] block_in,
  input  logic         block_valid,
  output logic         block_ready,
  output logic [31:0]  word_out,
  output logic         word_valid,
  input  logic         word_ready
`ifdef CHACHA20_SERIALIZER_STATS_EN
  ,
  output logic [15:0]  block_count
`endif
);

  localparam int IDX_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [IDX_W-1:0]              r_index;
  logic [IDX_W-1:0]              w_index_next;
  logic [32*WORDS_PER_BLOCK-1:0] r_holding;
  logic [31:0]                   w_words [WORDS_PER_BLOCK];
  logic                          w_last;
  logic                          w_accept;
  logic                          w_consume;

  // Only the words that can ever be emitted are held.
  always_ff @(posedge clock) begin
    if (w_accept && !clear) begin
      r_holding <= block_in[32*WORDS_PER_BLOCK-1:0];
    end
  end

  for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_words
    assign w_words[gi] = r_holding[32*gi +: 32];
  end

  assign word_out = w_words[r_index];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
      r_index <= '0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    word_valid   = (r_state == SERVE);
    w_last       = (r_index == LAST_IDX);
    // block_ready must not depend on block_valid: it comes from state,
    // index and word_ready only.
    block_ready  = (r_state == EMPTY) || ((r_state == SERVE) && w_last && word_ready);
    w_accept     = block_valid && block_ready;
    w_consume    = word_valid && word_ready;

    if (w_accept) begin
      // Covers both loading from EMPTY and reloading as the last word leaves.
      w_state_next = SERVE;
      w_index_next = '0;
    end else if (w_consume) begin
      if (w_last) begin
        w_state_next = EMPTY;
        w_index_next = '0;
      end else begin
        w_index_next = r_index + IDX_W'(1);
      end
    end

    // A clear wins over any accept or consume on the same edge.
    if (clear) begin
      w_state_next = EMPTY;
      w_index_next = '0;
    end
  end

`ifdef CHACHA20_SERIALIZER_STATS_EN
  logic [15:0] r_block_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_block_count <= '0;
    end else if (clear) begin
      r_block_count <= '0;
    end else if (w_accept) begin
      r_block_count <= r_block_count + 16'd1;
    end
  end

  assign block_count = r_block_count;
`endif

endmodule

// File: tb/tb_chacha20_word_serializer.sv
// tb_chacha20_word_serializer
//
// Directed bench for chacha20_word_serializer. It uses one 16-word instance
// and one 4-word instance, plus a 1-word instance that exercises the block
// counter when CHACHA20_SERIALIZER_STATS_EN is defined.

module tb_chacha20_word_serializer;

  logic         clock;
  logic         reset_n;
  logic         clear;
  logic [511:0] block_in;

  logic         v16, r16, br16, wv16;
  logic [31:0]  wo16;
  logic         v4, r4, br4, wv4;
  logic [31:0]  wo4;
`ifdef CHACHA20_SERIALIZER_STATS_EN
  logic         v1, r1, br1, wv1;
  logic [31:0]  wo1;
  logic [15:0]  cnt16, cnt4, cnt1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  chacha20_word_serializer #(.WORDS_PER_BLOCK(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .block_in(block_in),
    .block_valid(v16), .block_ready(br16), .word_out(wo16),
    .word_valid(wv16), .word_ready(r16)
`ifdef CHACHA20_SERIALIZER_STATS_EN
    , .block_count(cnt16)
`endif
  );

  chacha20_word_serializer #(.WORDS_PER_BLOCK(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .block_in(block_in),
    .block_valid(v4), .block_ready(br4), .word_out(wo4),
    .word_valid(wv4), .word_ready(r4)
`ifdef CHACHA20_SERIALIZER_STATS_EN
    , .block_count(cnt4)
`endif
  );

`ifdef CHACHA20_SERIALIZER_STATS_EN
  chacha20_word_serializer #(.WORDS_PER_BLOCK(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .block_in(block_in),
    .block_valid(v1), .block_ready(br1), .word_out(wo1),
    .word_valid(wv1), .word_ready(r1), .block_count(cnt1)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [511:0] mk_block(input logic [31:0] base);
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[32*k +: 32] = base + 32'(k);
    return b;
  endfunction

  logic [3:0] pat;
  int         idx;

  initial begin
    reset_n  = 1'b0;
    clear    = 1'b0;
    block_in = '0;
    v16 = 1'b0; r16 = 1'b0;
    v4  = 1'b0; r4  = 1'b0;
`ifdef CHACHA20_SERIALIZER_STATS_EN
    v1  = 1'b0; r1  = 1'b0;
`endif
    #2;
    check("reset_word_valid", 32'(wv16), 32'd0);
    check("reset_block_ready", 32'(br16), 32'd1);
    #10 reset_n = 1'b1;
    step();

    // Words 0..15 with word k = k, consumed every cycle.
    block_in = mk_block(32'h0);
    v16 = 1'b1; r16 = 1'b1;
    #1 check("t1_ready_empty", 32'(br16), 32'd1);
    step();
    v16 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("t1_valid_%0d", k), 32'(wv16), 32'd1);
      check($sformatf("t1_word_%0d", k), wo16, 32'(k));
      check($sformatf("t1_bready_%0d", k), 32'(br16), (k == 15) ? 32'd1 : 32'd0);
      step();
    end
    #1 check("t1_done_valid", 32'(wv16), 32'd0);

    // Back-to-back blocks A and B with block_valid held.
    block_in = mk_block(32'hA000_0000);
    v16 = 1'b1;
    #1;
    step();
    block_in = mk_block(32'hB000_0000);
    for (int i = 0; i < 32; i++) begin
      #1;
      check($sformatf("t2_valid_%0d", i), 32'(wv16), 32'd1);
      check($sformatf("t2_word_%0d", i), wo16,
            (i < 16) ? (32'hA000_0000 + 32'(i)) : (32'hB000_0000 + 32'(i - 16)));
      check($sformatf("t2_bready_%0d", i), 32'(br16),
            (i == 15 || i == 31) ? 32'd1 : 32'd0);
      step();
      if (i == 15) v16 = 1'b0;
    end
    #1 check("t2_done_valid", 32'(wv16), 32'd0);

    // Stalls: word_ready pattern 1,0,0,1 repeating.
    block_in = mk_block(32'hC000_0000);
    v16 = 1'b1;
    #1;
    step();
    v16 = 1'b0;
    pat = 4'b1001;
    idx = 0;
    for (int c = 0; c < 64 && idx < 16; c++) begin
      r16 = pat[c % 4];
      #1;
      check($sformatf("t3_valid_c%0d", c), 32'(wv16), 32'd1);
      check($sformatf("t3_word_c%0d", c), wo16, 32'hC000_0000 + 32'(idx));
      step();
      if (pat[c % 4]) idx++;
    end
    check("t3_all_consumed", 32'(idx), 32'd16);
    r16 = 1'b1;
    #1 check("t3_done_valid", 32'(wv16), 32'd0);

    // Four-word instance: words 4..15 of the block are never emitted.
    block_in = mk_block(32'hD000_0000);
    v4 = 1'b1; r4 = 1'b1;
    #1 check("t4_ready_empty", 32'(br4), 32'd1);
    step();
    v4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t4_valid_%0d", k), 32'(wv4), 32'd1);
      check($sformatf("t4_word_%0d", k), wo4, 32'hD000_0000 + 32'(k));
      check($sformatf("t4_bready_%0d", k), 32'(br4), (k == 3) ? 32'd1 : 32'd0);
      step();
    end
    #1 check("t4_done_valid", 32'(wv4), 32'd0);

    // Asynchronous reset at index 7.
    block_in = mk_block(32'hE000_0000);
    v16 = 1'b1; r16 = 1'b1;
    step();
    v16 = 1'b0;
    repeat (7) step();
    #1 check("t5_word7_before_reset", wo16, 32'hE000_0007);
    #1 reset_n = 1'b0;
    #1;
    check("t5_reset_valid_async", 32'(wv16), 32'd0);
    check("t5_reset_ready_async", 32'(br16), 32'd1);
    step();
    step();
    #2 reset_n = 1'b1;
    step();
    check("t5_after_release_valid", 32'(wv16), 32'd0);
    block_in = mk_block(32'hF000_0000);
    v16 = 1'b1;
    step();
    v16 = 1'b0;
    #1;
    check("t5_new_block_valid", 32'(wv16), 32'd1);
    check("t5_new_block_word0", wo16, 32'hF000_0000);
    repeat (7) step();
    #1 check("t5_word7_before_clear", wo16, 32'hF000_0007);

    // Clear at index 7, with a block offered on the same edge.
    clear = 1'b1;
    block_in = mk_block(32'h1234_0000);
    v16 = 1'b1;
    step();
    clear = 1'b0;
    v16 = 1'b0;
    #1;
    check("t5_clear_valid", 32'(wv16), 32'd0);
    check("t5_clear_ready", 32'(br16), 32'd1);
    block_in = mk_block(32'h5678_0000);
    v16 = 1'b1;
    step();
    v16 = 1'b0;
    #1;
    check("t5_after_clear_word0", wo16, 32'h5678_0000);
    step();
    #1 check("t5_after_clear_word1", wo16, 32'h5678_0001);

`ifdef CHACHA20_SERIALIZER_STATS_EN
    // Block counter wraps after 65536 accepts; a clear zeroes it.
    check("t6_count_start", 32'(cnt1), 32'd0);
    v1 = 1'b1; r1 = 1'b1;
    repeat (65537) step();
    v1 = 1'b0;
    #1 check("t6_count_wrapped", 32'(cnt1), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1 check("t6_count_cleared", 32'(cnt1), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
